// File: rtl/cdb_pkg.sv
// Common data bus word layout, idle word and destination register encodings
// shared by the CDB arbiter and its result queue.
package cdb_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned DEST_MSB = 15;
  localparam int unsigned DEST_LSB = 13;
  localparam int unsigned RS_MSB   = 12;
  localparam int unsigned RS_LSB   = 11;
  localparam int unsigned SRC_BIT  = 10;
  localparam int unsigned DATA_MSB = 9;
  localparam int unsigned DATA_W   = 10;
  localparam int unsigned RS_IDX_W = 2;
  localparam int unsigned RS_NUM   = 4;

  localparam logic [WORD_W-1:0] CDB_INVALID_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    REG_R0 = 3'b001,
    REG_R1 = 3'b010,
    REG_R2 = 3'b100
  } reg_onehot_e;

  function automatic logic dest_is_onehot(input logic [2:0] dest);
    return (dest == REG_R0) || (dest == REG_R1) || (dest == REG_R2);
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Result queue: up to two pushes (a before b) and one pop per clock.
// The caller guarantees pushes fit and pop only happens when count != 0.
module cdb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_a,
  input  logic [WIDTH-1:0]         data_a,
  input  logic                     push_b,
  input  logic [WIDTH-1:0]         data_b,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // second push lands in the slot after the first, pointers wrap by width
    if (push_a) begin
      mem_d[wr_ptr_d] = data_a;
      wr_ptr_d        = wr_ptr_d + PTR_W'(1);
    end
    if (push_b) begin
      mem_d[wr_ptr_d] = data_b;
      wr_ptr_d        = wr_ptr_d + PTR_W'(1);
    end
    count_d = count_q - CNT_W'(pop) + CNT_W'(push_a) + CNT_W'(push_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Validates ULA and load/store ULA results, queues well-formed words and
// broadcasts one per clock on the registered CDB with decoded side outputs.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter logic [15:0] INVALID_WORD = CDB_INVALID_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ula_in,
  input  logic [15:0] ula_ldsd_in,
  output logic [15:0] cdb,
  output logic [2:0]  reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic [3:0]  rs_free,
  output logic        queue_full,
  output logic        overflow,
  output logic [7:0]  malformed_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             a_valid, b_valid, a_ok, b_ok, a_bad, b_bad;
  logic             pop, push_a, push_b, drop;
  logic [CNT_W-1:0] count, free_slots;
  logic [15:0]      head;
  logic [8:0]       mal_sum;

  logic [15:0] cdb_q, cdb_d;
  logic [2:0]  reg_wr_en_q, reg_wr_en_d;
  logic [15:0] reg_wr_data_q, reg_wr_data_d;
  logic [3:0]  rs_free_q, rs_free_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  mal_q, mal_d;

  always_comb begin
    a_valid = (ula_in != INVALID_WORD);
    b_valid = (ula_ldsd_in != INVALID_WORD);
    a_ok    = a_valid && dest_is_onehot(ula_in[DEST_MSB:DEST_LSB]);
    b_ok    = b_valid && dest_is_onehot(ula_ldsd_in[DEST_MSB:DEST_LSB]);
    a_bad   = a_valid && !a_ok;
    b_bad   = b_valid && !b_ok;

    pop = (count != '0);
    // space freed by this edge's pop is usable by this edge's pushes
    free_slots = CNT_W'(DEPTH) - count + CNT_W'(pop);
    push_a     = a_ok && (free_slots >= CNT_W'(1));
    push_b     = b_ok && (free_slots >= (a_ok ? CNT_W'(2) : CNT_W'(1)));
    drop       = (a_ok && !push_a) || (b_ok && !push_b);

    cdb_d         = INVALID_WORD;
    reg_wr_en_d   = '0;
    reg_wr_data_d = '0;
    rs_free_d     = '0;
    if (pop) begin
      cdb_d         = head;
      reg_wr_en_d   = head[DEST_MSB:DEST_LSB];
      reg_wr_data_d = {6'b0, head[DATA_MSB:0]};
      rs_free_d     = RS_NUM'(1) << head[RS_MSB:RS_LSB];
    end

    overflow_d = overflow_q || drop;
    mal_sum    = {1'b0, mal_q} + 9'(a_bad) + 9'(b_bad);
    mal_d      = mal_sum[8] ? 8'hFF : mal_sum[7:0];
  end

  cdb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk    (clock),
    .rst    (reset),
    .push_a (push_a),
    .data_a (ula_in),
    .push_b (push_b),
    .data_b (ula_ldsd_in),
    .pop    (pop),
    .head   (head),
    .count  (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_q         <= INVALID_WORD;
      reg_wr_en_q   <= '0;
      reg_wr_data_q <= '0;
      rs_free_q     <= '0;
      overflow_q    <= 1'b0;
      mal_q         <= '0;
    end else begin
      cdb_q         <= cdb_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_data_q <= reg_wr_data_d;
      rs_free_q     <= rs_free_d;
      overflow_q    <= overflow_d;
      mal_q         <= mal_d;
    end
  end

  assign cdb             = cdb_q;
  assign reg_wr_en       = reg_wr_en_q;
  assign reg_wr_data     = reg_wr_data_q;
  assign rs_free         = rs_free_q;
  assign queue_full      = (count == CNT_W'(DEPTH));
  assign overflow        = overflow_q;
  assign malformed_count = mal_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [15:0] ula_in, ula_ldsd_in;
  logic [15:0] cdb;
  logic [2:0]  reg_wr_en;
  logic [15:0] reg_wr_data;
  logic [3:0]  rs_free;
  logic        queue_full, overflow;
  logic [7:0]  malformed_count;

  cdb_arbiter #(
    .DEPTH        (DEPTH),
    .INVALID_WORD (16'hFFFF)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ula_in          (ula_in),
    .ula_ldsd_in     (ula_ldsd_in),
    .cdb             (cdb),
    .reg_wr_en       (reg_wr_en),
    .reg_wr_data     (reg_wr_data),
    .rs_free         (rs_free),
    .queue_full      (queue_full),
    .overflow        (overflow),
    .malformed_count (malformed_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [15:0] mq[$];
  logic [15:0] e_cdb;
  logic [2:0]  e_wr;
  logic [15:0] e_wd;
  logic [3:0]  e_rs;
  logic        e_ovf;
  int          e_mal;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [15:0] w);
    if (w == 16'hFFFF) return;
    if ($countones(w[15:13]) == 1) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else e_ovf = 1'b1;
    end else begin
      e_mal = (e_mal + 1 > 255) ? 255 : e_mal + 1;
    end
  endtask

  task automatic model_edge(input logic [15:0] a, input logic [15:0] b, input logic r);
    logic [15:0] w;
    if (r) begin
      mq.delete();
      e_cdb = 16'hFFFF; e_wr = '0; e_wd = '0; e_rs = '0;
      e_ovf = 1'b0; e_mal = 0;
      return;
    end
    if (mq.size() > 0) begin
      w     = mq.pop_front();
      e_cdb = w;
      e_wr  = w[15:13];
      e_wd  = {6'b0, w[9:0]};
      e_rs  = 4'(1 << w[12:11]);
    end else begin
      e_cdb = 16'hFFFF; e_wr = '0; e_wd = '0; e_rs = '0;
    end
    model_accept(a);
    model_accept(b);
  endtask

  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic r);
    ula_in      = a;
    ula_ldsd_in = b;
    reset       = r;
    @(posedge clock);
    model_edge(a, b, r);
    #1;
    chk("model_cdb", 32'(cdb), 32'(e_cdb));
    chk("model_reg_wr_en", 32'(reg_wr_en), 32'(e_wr));
    chk("model_reg_wr_data", 32'(reg_wr_data), 32'(e_wd));
    chk("model_rs_free", 32'(rs_free), 32'(e_rs));
    chk("model_queue_full", 32'(queue_full), 32'(mq.size() == DEPTH));
    chk("model_overflow", 32'(overflow), 32'(e_ovf));
    chk("model_malformed", 32'(malformed_count), 32'(e_mal));
  endtask

  function automatic logic [15:0] rand_word();
    int unsigned sel;
    logic [2:0]  dest;
    logic [2:0]  bad_dest [5];
    sel = $urandom_range(0, 9);
    bad_dest[0] = 3'b000; bad_dest[1] = 3'b011; bad_dest[2] = 3'b101;
    bad_dest[3] = 3'b110; bad_dest[4] = 3'b111;
    if (sel < 4) return 16'hFFFF;
    if (sel < 9) begin
      dest = 3'(1 << $urandom_range(0, 2));
    end else begin
      dest = bad_dest[$urandom_range(0, 4)];
    end
    return {dest, 13'($urandom)};
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] cdb;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic [3:0]  rs;
    logic [7:0]  mal;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [15:0] wa(input int i);
    return {3'b010, 2'(i), 1'b1, 10'(i + 16)};
  endfunction

  function automatic logic [15:0] wb(input int i);
    return {3'b100, 2'(i), 1'b0, 10'(i + 32)};
  endfunction

  initial begin
    ula_in      = 16'hFFFF;
    ula_ldsd_in = 16'hFFFF;
    reset       = 1'b1;

    tbl[0] = '{16'h4C25, 16'hFFFF, 16'hFFFF, 3'b000, 16'h0000, 4'b0000, 8'd0};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 16'h4C25, 3'b010, 16'h0025, 4'b0010, 8'd0};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 3'b000, 16'h0000, 4'b0000, 8'd0};
    tbl[3] = '{16'h4C25, 16'h3005, 16'hFFFF, 3'b000, 16'h0000, 4'b0000, 8'd0};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 16'h4C25, 3'b010, 16'h0025, 4'b0010, 8'd0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 16'h3005, 3'b001, 16'h0005, 4'b0100, 8'd0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 3'b000, 16'h0000, 4'b0000, 8'd0};
    tbl[7] = '{16'hC025, 16'hFFFF, 16'hFFFF, 3'b000, 16'h0000, 4'b0000, 8'd1};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 3'b000, 16'h0000, 4'b0000, 8'd1};

    step(16'hFFFF, 16'hFFFF, 1'b1);
    step(16'hFFFF, 16'hFFFF, 1'b1);
    chk("reset_cdb", 32'(cdb), 32'h0000FFFF);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_malformed", 32'(malformed_count), 32'd0);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].a, tbl[i].b, 1'b0);
      chk($sformatf("tbl%0d_cdb", i), 32'(cdb), 32'(tbl[i].cdb));
      chk($sformatf("tbl%0d_wr_en", i), 32'(reg_wr_en), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_wr_data", i), 32'(reg_wr_data), 32'(tbl[i].wd));
      chk($sformatf("tbl%0d_rs_free", i), 32'(rs_free), 32'(tbl[i].rs));
      chk($sformatf("tbl%0d_malformed", i), 32'(malformed_count), 32'(tbl[i].mal));
    end

    // fill to full, pop+single push on full, then a dropped ldsd word
    step(16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < 3; i++) step(wa(i), wb(i), 1'b0);
    chk("fill_queue_full", 32'(queue_full), 32'd1);
    chk("fill_overflow", 32'(overflow), 32'd0);
    step(wa(3), 16'hFFFF, 1'b0);
    chk("full_pop_push_full", 32'(queue_full), 32'd1);
    chk("full_pop_push_ovf", 32'(overflow), 32'd0);
    step(wa(4), wb(4), 1'b0);
    chk("drop_overflow", 32'(overflow), 32'd1);
    step(16'hFFFF, 16'hFFFF, 1'b0);
    step(16'hFFFF, 16'hFFFF, 1'b0);
    step(16'hFFFF, 16'hFFFF, 1'b0);
    step(16'hFFFF, 16'hFFFF, 1'b0);
    chk("drain_last_word", 32'(cdb), 32'(wa(4)));
    step(16'hFFFF, 16'hFFFF, 1'b0);
    chk("drain_idle_cdb", 32'(cdb), 32'h0000FFFF);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // malformed saturation: two bad words per cycle
    step(16'hFFFF, 16'hFFFF, 1'b1);
    step(16'hC025, 16'hE001, 1'b0);
    chk("mal_double", 32'(malformed_count), 32'd2);
    for (int i = 1; i < 150; i++) step(16'hC025, 16'hE001, 1'b0);
    chk("mal_saturate", 32'(malformed_count), 32'd255);
    chk("mal_no_broadcast", 32'(cdb), 32'h0000FFFF);

    // reset with three queued words and a word on the input
    step(16'h0025, 16'hFFFF, 1'b0);
    step(wa(0), wb(0), 1'b0);
    step(wa(1), wb(1), 1'b0);
    step(16'h4C25, 16'hFFFF, 1'b1);
    chk("rst_mid_cdb", 32'(cdb), 32'h0000FFFF);
    chk("rst_mid_full", 32'(queue_full), 32'd0);
    chk("rst_mid_malformed", 32'(malformed_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(16'hFFFF, 16'hFFFF, 1'b0);
      chk($sformatf("rst_mid_idle%0d", i), 32'(cdb), 32'h0000FFFF);
    end
    step(16'h3005, 16'hFFFF, 1'b0);
    step(16'hFFFF, 16'hFFFF, 1'b0);
    chk("post_reset_first", 32'(cdb), 32'h00003005);

    for (int i = 0; i < 3000; i++) begin
      step(rand_word(), rand_word(), ($urandom_range(0, 149) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
